stepper_axis_ctrl: RTL and testbench
====================================

# stepper_axis_ctrl

Parametrised multi-channel step/direction motor controller with an Avalon-MM slave register port, replacing the fixed 16-bit motor PIO outputs of the SOPC system with hardware step generation. Each channel executes a signed step count at a programmed period, tracks absolute position and reports completion. It sits on the Nios II data bus beside the SPI/UART/PIO peripherals; step/dir lines go straight to the driver pins.

## Interface

- NUM_CH, 4, number of independent axes (1–8)
- CNT_W, 24, width of period, count and position registers (8–32)
- PULSE_W, 50, step-high time in clocks (≥1)
- DIR_SETUP, 25, clocks between dir update and first step rising edge (≥1)

- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_address  in  $clog2(NUM_CH)+2  {channel, reg[1:0]}
- avs_write  in  1  write strobe, zero wait states
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, fixed read latency 1
- step_export  out  NUM_CH  step pulses, active high
- dir_export  out  NUM_CH  direction, 1 = positive
- irq  out  1  level interrupt (see Configuration)

## Operation

- Registers per channel: reg0 CTRL/STATUS, reg1 PERIOD, reg2 COUNT, reg3 POSITION. Unused upper bits read 0; CNT_W fields sign-extended on read for COUNT/POSITION.
- CTRL write: bit0 START, bit1 ABORT, bit2 clear DONE, bit3 IRQ_ENABLE (stored). STATUS read: bit0 BUSY, bit1 DONE (sticky), bit3 IRQ_ENABLE.
- PERIOD: clocks per step; effective period = max(PERIOD, PULSE_W+1). Latched at each HIGH entry, so writes while busy apply from the next step.
- COUNT: signed steps. Write ignored while BUSY. Read returns remaining signed count (sign preserved, magnitude decreasing).
- POSITION: signed, ±1 per step at step rising edge, wraps modulo 2^CNT_W. Write ignored while BUSY.
- Per-channel FSM: IDLE → SETUP (DIR_SETUP cycles, dir_export = COUNT ≥ 0) → HIGH (PULSE_W cycles, step=1) → LOW (period−PULSE_W cycles) → HIGH if remaining ≠ 0, else IDLE with DONE=1.
- START in IDLE with COUNT=0: no SETUP, DONE=1 next cycle, BUSY never asserted.
- START while BUSY ignored. START and ABORT in same write: ABORT wins.
- ABORT: any state → IDLE next cycle, step forced 0 immediately (may truncate pulse), remaining COUNT preserved, DONE not set. Truncated pulse counted in POSITION only if HIGH was already entered.
- Clearing DONE and a completion in the same cycle: DONE ends set.
- Channels fully independent; no cross-channel interaction.
- Reset mid-operation: all state to reset values instantly; motion lost.

## Timing

- Reset values: avs_readdata=0, step_export=0, dir_export=all 1, irq=0; PERIOD=0, COUNT=0, POSITION=0, DONE=0, IRQ_ENABLE=0, FSMs IDLE.
- Write accepted on the rising edge with avs_write=1; effect visible next cycle.
- Read: avs_readdata valid the cycle after avs_read, holds until next read.
- START accepted at edge T: BUSY=1 from T+1; first step rising at T+1+DIR_SETUP; step k rises at T+1+DIR_SETUP+(k−1)·period.
- Last step: DONE=1 and BUSY=0 at the cycle the final LOW phase ends.
- POSITION/COUNT update in the cycle step rises.

## Configuration

- STEPPER_IRQ_EN defined: irq = OR over channels of (DONE & IRQ_ENABLE), registered (one cycle after DONE). Not defined: irq tied 0, IRQ_ENABLE bit stores but has no effect, no irq logic synthesised.

## Test plan

- Reset: assert reset_reset_n=0 mid-motion -> step=0, dir=all 1, irq=0, all registers read 0 after release.
- Ch0 PERIOD=100, COUNT=+3, START at T -> dir0=1, steps rise at T+26, T+126, T+226, each 50 cycles high; POSITION=3, COUNT=0, DONE=1 at T+326.
- Ch2 COUNT=−2, PERIOD=10 (clamped to 51) -> dir2=0, rises 51 cycles apart, POSITION=−2; POSITION=0x7FFFFF, COUNT=+1 -> POSITION reads 0xFF800000.
- ABORT during second of 5 steps -> step falls next cycle, BUSY=0, DONE=0, COUNT reads +3 or +4 per rule; START+ABORT same write -> no motion.
- START with COUNT=0 -> no step pulses, DONE=1 next cycle; writes to COUNT/POSITION while BUSY -> readback unchanged.
- STEPPER_IRQ_EN defined, IRQ_ENABLE=1 on ch1 and ch3 -> irq rises one cycle after first DONE, stays until both DONE bits cleared; undefined -> irq stays 0.

Source files
------------

// File: rtl/stepper_axis_ctrl.sv
// stepper_axis_ctrl: multi-axis step/dir pulse generator behind an Avalon-MM slave.
// Define STEPPER_IRQ_EN to build the level interrupt (DONE & IRQ_ENABLE).
module stepper_axis_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 24,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 25
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [$clog2(NUM_CH)+1:0] avs_address,
    input  logic                      avs_write,
    input  logic [31:0]               avs_writedata,
    input  logic                      avs_read,
    output logic [31:0]               avs_readdata,
    output logic [NUM_CH-1:0]         step_export,
    output logic [NUM_CH-1:0]         dir_export,
    output logic                      irq
);

    localparam logic [CNT_W-1:0] PW    = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] DS_LD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] PW_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } st_t;

    st_t              st_q  [NUM_CH];
    logic [CNT_W-1:0] per_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] pos_q [NUM_CH];
    logic [CNT_W-1:0] tmr_q [NUM_CH];
    logic [CNT_W-1:0] low_q [NUM_CH];

    logic [NUM_CH-1:0] step_q, dir_q, done_q, ien_q;
    logic [NUM_CH-1:0] ctl_wr, per_wr, cnt_wr, pos_wr;
    logic [NUM_CH-1:0] busy, abort, start, go_high;
    logic [CNT_W-1:0]  wd;
    logic [31:0]       rd_val;
    int                ch_sel;
    logic              unused_wd;

    assign wd          = avs_writedata[CNT_W-1:0];
    assign unused_wd   = ^avs_writedata;
    assign ch_sel      = int'(avs_address >> 2);
    assign step_export = step_q;
    assign dir_export  = dir_q;

    // LOW-phase timer load: effective period minus pulse width, minus one
    function automatic logic [CNT_W-1:0] low_load(input logic [CNT_W-1:0] p);
        return ((p > PW) ? p : PMIN) - PW - ONE;
    endfunction

    always_comb begin
        ctl_wr  = '0;
        per_wr  = '0;
        cnt_wr  = '0;
        pos_wr  = '0;
        busy    = '0;
        abort   = '0;
        start   = '0;
        go_high = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctl_wr[i]  = avs_write && ch_sel == i && avs_address[1:0] == 2'd0;
            per_wr[i]  = avs_write && ch_sel == i && avs_address[1:0] == 2'd1;
            cnt_wr[i]  = avs_write && ch_sel == i && avs_address[1:0] == 2'd2;
            pos_wr[i]  = avs_write && ch_sel == i && avs_address[1:0] == 2'd3;
            busy[i]    = st_q[i] != ST_IDLE;
            abort[i]   = ctl_wr[i] && avs_writedata[1];
            start[i]   = ctl_wr[i] && avs_writedata[0] && !avs_writedata[1] && !busy[i];
            go_high[i] = !abort[i] && tmr_q[i] == '0 &&
                         (st_q[i] == ST_SETUP ||
                          (st_q[i] == ST_LOW && cnt_q[i] != '0));
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= ST_IDLE;
                per_q[i] <= '0;
                cnt_q[i] <= '0;
                pos_q[i] <= '0;
                tmr_q[i] <= '0;
                low_q[i] <= '0;
            end
            step_q <= '0;
            dir_q  <= '1;
            done_q <= '0;
            ien_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctl_wr[i]) ien_q[i] <= avs_writedata[3];
                if (ctl_wr[i] && avs_writedata[2]) done_q[i] <= 1'b0;
                if (per_wr[i]) per_q[i] <= wd;
                if (go_high[i]) begin
                    st_q[i]   <= ST_HIGH;
                    step_q[i] <= 1'b1;
                    tmr_q[i]  <= PW_LD;
                    low_q[i]  <= low_load(per_q[i]);
                    cnt_q[i]  <= dir_q[i] ? cnt_q[i] - ONE : cnt_q[i] + ONE;
                    pos_q[i]  <= dir_q[i] ? pos_q[i] + ONE : pos_q[i] - ONE;
                end else if (abort[i]) begin
                    st_q[i]   <= ST_IDLE;
                    step_q[i] <= 1'b0;
                end else begin
                    unique case (st_q[i])
                        ST_IDLE: begin
                            if (cnt_wr[i]) cnt_q[i] <= wd;
                            if (pos_wr[i]) pos_q[i] <= wd;
                            if (start[i]) begin
                                if (cnt_q[i] == '0) begin
                                    done_q[i] <= 1'b1;
                                end else begin
                                    st_q[i]  <= ST_SETUP;
                                    tmr_q[i] <= DS_LD;
                                    dir_q[i] <= !cnt_q[i][CNT_W-1];
                                end
                            end
                        end
                        ST_SETUP: tmr_q[i] <= tmr_q[i] - ONE;
                        ST_HIGH: begin
                            if (tmr_q[i] == '0) begin
                                st_q[i]   <= ST_LOW;
                                step_q[i] <= 1'b0;
                                tmr_q[i]  <= low_q[i];
                            end else begin
                                tmr_q[i] <= tmr_q[i] - ONE;
                            end
                        end
                        ST_LOW: begin
                            if (tmr_q[i] == '0) begin
                                st_q[i]   <= ST_IDLE;
                                done_q[i] <= 1'b1;
                            end else begin
                                tmr_q[i] <= tmr_q[i] - ONE;
                            end
                        end
                        default: st_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == i) begin
                case (avs_address[1:0])
                    2'd0:    rd_val = {28'd0, ien_q[i], 1'b0, done_q[i], busy[i]};
                    2'd1:    rd_val = 32'(per_q[i]);
                    2'd2:    rd_val = 32'($signed(cnt_q[i]));
                    default: rd_val = 32'($signed(pos_q[i]));
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_val;
    end

`ifdef STEPPER_IRQ_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) irq <= 1'b0;
        else irq <= |(done_q & ien_q);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Bench for stepper_axis_ctrl: timeline model of each move plus directed
// literal checks of register readback, abort, wrap and interrupt behaviour.
module tb_stepper_axis_ctrl;
    localparam int NCH = 4;
    localparam int CW  = 24;
    localparam int PW  = 50;
    localparam int DS  = 25;
    localparam int BIG = 1 << 30;
`ifdef STEPPER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [3:0]  step_export, dir_export;
    logic        irq;

    stepper_axis_ctrl #(
        .NUM_CH(NCH), .CNT_W(CW), .PULSE_W(PW), .DIR_SETUP(DS)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(avs_readdata), .step_export(step_export),
        .dir_export(dir_export), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    bit irq_quiet = 1'b1;

    // Each move: issued in cycle t, n steps of period p, sign sgn, cut off at ab.
    int m_t[NCH], m_n[NCH], m_p[NCH], m_sgn[NCH], m_ab[NCH], m_zd[NCH];
    int m_cnt[NCH], m_pos[NCH], m_per[NCH];
    bit m_valid[NCH], m_dnew[NCH], m_dold[NCH], m_done[NCH], m_ien[NCH];

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_valid[ch] = 0; m_dold[ch] = 1; m_dnew[ch] = 1;
            m_done[ch] = 0; m_ien[ch] = 0; m_zd[ch] = BIG; m_ab[ch] = BIG;
            m_cnt[ch] = 0; m_pos[ch] = 0; m_per[ch] = 0;
            m_t[ch] = 0; m_n[ch] = 0; m_p[ch] = PW + 1; m_sgn[ch] = 1;
        end
    endfunction

    function automatic int mv_end(int ch);
        return m_t[ch] + 1 + DS + m_n[ch] * m_p[ch];
    endfunction

    function automatic bit exp_step(int ch, int c);
        int off;
        if (!m_valid[ch] || c >= m_ab[ch]) return 0;
        off = c - (m_t[ch] + 1 + DS);
        if (off < 0 || off / m_p[ch] >= m_n[ch]) return 0;
        return (off % m_p[ch]) < PW;
    endfunction

    function automatic bit exp_dir(int ch, int c);
        return (m_valid[ch] && c >= m_t[ch] + 1) ? m_dnew[ch] : m_dold[ch];
    endfunction

    function automatic bit exp_busy(int ch, int c);
        return m_valid[ch] && c >= m_t[ch] + 1 && c < mv_end(ch) && c < m_ab[ch];
    endfunction

    function automatic bit completed(int ch, int c);
        return m_valid[ch] && mv_end(ch) <= c && mv_end(ch) < m_ab[ch];
    endfunction

    function automatic int risen(int ch, int c);
        int cc, off, k;
        if (!m_valid[ch]) return 0;
        cc = (c < m_ab[ch]) ? c : m_ab[ch] - 1;
        off = cc - (m_t[ch] + 1 + DS);
        if (off < 0) return 0;
        k = off / m_p[ch] + 1;
        return (k > m_n[ch]) ? m_n[ch] : k;
    endfunction

    function automatic logic [31:0] sx(int v);
        int s;
        s = v <<< (32 - CW);
        return s >>> (32 - CW);
    endfunction

    function automatic logic [31:0] exp_reg(int ch, int rg, int c);
        case (rg)
            0: return {28'd0, m_ien[ch], 1'b0,
                       m_done[ch] || c >= m_zd[ch] || completed(ch, c),
                       exp_busy(ch, c)};
            1: return m_per[ch];
            2: return sx(m_cnt[ch] - m_sgn[ch] * risen(ch, c));
            default: return sx(m_pos[ch] + m_sgn[ch] * risen(ch, c));
        endcase
    endfunction

    // Fold a finished move into the base values so the next move starts clean.
    function automatic void retire(int ch, int c);
        int k;
        if (!m_valid[ch]) return;
        k = risen(ch, c);
        m_pos[ch] = m_pos[ch] + m_sgn[ch] * k;
        m_cnt[ch] = m_cnt[ch] - m_sgn[ch] * k;
        if (completed(ch, c)) m_done[ch] = 1;
        m_dold[ch] = exp_dir(ch, c);
        m_valid[ch] = 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int ch = 0; ch < NCH; ch++) begin
                n_chk++;
                if (step_export[ch] !== exp_step(ch, cyc)) begin
                    n_fail++;
                    $display("FAIL step%0d: got %b expected %b (cycle %0d)",
                             ch, step_export[ch], exp_step(ch, cyc), cyc);
                end
                n_chk++;
                if (dir_export[ch] !== exp_dir(ch, cyc)) begin
                    n_fail++;
                    $display("FAIL dir%0d: got %b expected %b (cycle %0d)",
                             ch, dir_export[ch], exp_dir(ch, cyc), cyc);
                end
            end
            if (irq_quiet) begin
                n_chk++;
                if (irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL irq_idle: got %b expected 0 (cycle %0d)", irq, cyc);
                end
            end
        end
    end

    task automatic wr(input int ch, input int rg, input logic [31:0] d, output int t);
        @(negedge clk);
        t = cyc;
        avs_address = 4'(ch * 4 + rg);
        avs_writedata = d;
        avs_write = 1'b1;
        @(posedge clk);
        #1 avs_write = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] q, output int c);
        @(negedge clk);
        c = cyc;
        avs_address = 4'(ch * 4 + rg);
        avs_read = 1'b1;
        @(posedge clk);
        #1 avs_read = 1'b0;
        q = avs_readdata;
    endtask

    task automatic rdm(input int ch, input int rg, input string nm);
        logic [31:0] q;
        int c;
        rd(ch, rg, q, c);
        check(nm, q, exp_reg(ch, rg, c));
    endtask

    task automatic rdl(input int ch, input int rg, input string nm, input logic [31:0] lit);
        logic [31:0] q;
        int c;
        rd(ch, rg, q, c);
        check(nm, q, lit);
        check({nm, "_model"}, exp_reg(ch, rg, c), lit);
    endtask

    task automatic wper(input int ch, input int v);
        int t;
        wr(ch, 1, v, t);
        m_per[ch] = v;
    endtask

    task automatic wcnt(input int ch, input int v, input bit is_pos);
        int t;
        wr(ch, is_pos ? 3 : 2, v, t);
        if (!exp_busy(ch, t)) begin
            retire(ch, t);
            if (is_pos) m_pos[ch] = v;
            else m_cnt[ch] = v;
        end
    endtask

    task automatic ctrl(input int ch, input logic [31:0] d, output int t);
        bit bz;
        wr(ch, 0, d, t);
        bz = exp_busy(ch, t);
        m_ien[ch] = d[3];
        if (d[2]) begin
            if (!bz) retire(ch, t);
            m_done[ch] = 0;
            m_zd[ch] = BIG;
        end
        if (d[1]) begin
            if (bz) m_ab[ch] = t + 1;
        end else if (d[0] && !bz) begin
            retire(ch, t);
            if (sx(m_cnt[ch]) == 0) begin
                m_zd[ch] = t + 1;
            end else begin
                m_valid[ch] = 1; m_t[ch] = t; m_ab[ch] = BIG;
                m_sgn[ch] = (int'(sx(m_cnt[ch])) < 0) ? -1 : 1;
                m_n[ch] = m_sgn[ch] * int'(sx(m_cnt[ch]));
                m_p[ch] = (m_per[ch] > PW) ? m_per[ch] : PW + 1;
                m_dnew[ch] = m_sgn[ch] > 0;
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        if (cyc > c) check("wait_cyc_late", cyc, c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_step", {28'd0, step_export}, 32'd0);
        check("rst_dir", {28'd0, dir_export}, 32'hF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, t2, t, a;
        model_reset();
        @(negedge clk);
        chk_on = 1'b1;
        check("init_step", {28'd0, step_export}, 32'd0);
        check("init_dir", {28'd0, dir_export}, 32'hF);
        check("init_rdata", avs_readdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdl(0, 0, "init_status", 32'd0);
        rdl(2, 3, "init_pos", 32'd0);

        // ch0 three positive steps, ch2 two negative steps with clamped period
        wper(0, 100);
        wcnt(0, 3, 0);
        ctrl(0, 32'h1, t0);
        wper(2, 10);
        wcnt(2, -2, 0);
        ctrl(2, 32'h1, t2);
        wait_cyc(t0 + 25); check("ch0_pre", {31'd0, step_export[0]}, 32'd0);
        wait_cyc(t0 + 26); check("ch0_rise1", {31'd0, step_export[0]}, 32'd1);
        check("ch0_dir", {31'd0, dir_export[0]}, 32'd1);
        wait_cyc(t2 + 26); check("ch2_rise1", {31'd0, step_export[2]}, 32'd1);
        check("ch2_dir", {31'd0, dir_export[2]}, 32'd0);
        wait_cyc(t0 + 75); check("ch0_hi_end", {31'd0, step_export[0]}, 32'd1);
        wait_cyc(t0 + 76); check("ch0_fall", {31'd0, step_export[0]}, 32'd0);
        wait_cyc(t2 + 76); check("ch2_gap", {31'd0, step_export[2]}, 32'd0);
        wait_cyc(t2 + 77); check("ch2_rise2", {31'd0, step_export[2]}, 32'd1);
        wait_cyc(t0 + 126); check("ch0_rise2", {31'd0, step_export[0]}, 32'd1);
        wait_cyc(t0 + 226); check("ch0_rise3", {31'd0, step_export[0]}, 32'd1);
        wait_cyc(t0 + 324);
        rdl(0, 0, "ch0_busy_last", 32'h1);
        rdl(0, 0, "ch0_done", 32'h2);
        rdl(0, 3, "ch0_pos", 32'd3);
        rdl(0, 2, "ch0_cnt", 32'd0);
        rdl(2, 3, "ch2_pos", 32'hFFFF_FFFE);
        rdl(2, 2, "ch2_cnt", 32'd0);
        rdm(2, 0, "ch2_status");

        // position wrap at the signed CNT_W boundary
        wcnt(2, 32'h7F_FFFF, 1);
        wcnt(2, 1, 0);
        ctrl(2, 32'h5, t);
        wait_cyc(t + 30);
        rdl(2, 3, "ch2_wrap", 32'hFF80_0000);
        wait_cyc(t + 80);
        rdm(2, 0, "ch2_wrap_status");

        // abort during the second of five steps, then START+ABORT together
        wper(1, 100);
        wcnt(1, 5, 0);
        ctrl(1, 32'h1, t);
        wait_cyc(t + 139);
        check("ch1_high_pre", {31'd0, step_export[1]}, 32'd1);
        ctrl(1, 32'h2, a);
        @(negedge clk);
        check("ch1_abort_fall", {31'd0, step_export[1]}, 32'd0);
        rdl(1, 0, "ch1_abort_status", 32'h0);
        rdl(1, 2, "ch1_abort_cnt", 32'd3);
        rdl(1, 3, "ch1_abort_pos", 32'd2);
        ctrl(1, 32'h3, t);
        repeat (60) @(negedge clk);
        rdl(1, 0, "ch1_sa_status", 32'h0);
        rdl(1, 2, "ch1_sa_cnt", 32'd3);

        // zero-count start completes without motion
        ctrl(3, 32'h1, t);
        rdl(3, 0, "ch3_zero_done", 32'h2);
        repeat (40) @(negedge clk);
        rdm(3, 3, "ch3_zero_pos");

        // COUNT/POSITION writes while busy are ignored
        ctrl(0, 32'h4, t);
        wcnt(0, 2, 0);
        ctrl(0, 32'h1, t);
        wait_cyc(t + 30);
        rdl(0, 0, "ch0_busy", 32'h1);
        wcnt(0, 7, 0);
        wcnt(0, 99, 1);
        rdl(0, 2, "ch0_busy_cnt", 32'd1);
        rdl(0, 3, "ch0_busy_pos", 32'd4);
        wait_cyc(t + 1 + DS + 200 + 2);
        rdl(0, 2, "ch0_end_cnt", 32'd0);
        rdl(0, 3, "ch0_end_pos", 32'd5);

        // interrupt on ch1/ch3 DONE
        wcnt(1, 0, 0);
        ctrl(1, 32'hC, t);
        ctrl(3, 32'hC, t);
        rdl(1, 0, "ch1_ien", 32'h8);
        rdl(3, 0, "ch3_ien", 32'h8);
        irq_quiet = !IRQ_ON;
        ctrl(3, 32'h9, t);
        @(negedge clk); check("irq_t1", {31'd0, irq}, 32'd0);
        @(negedge clk); check("irq_t2", {31'd0, irq}, {31'd0, IRQ_ON});
        ctrl(1, 32'h9, t);
        ctrl(3, 32'hC, t);
        repeat (2) @(negedge clk);
        check("irq_ch1_hold", {31'd0, irq}, {31'd0, IRQ_ON});
        ctrl(1, 32'hC, t);
        @(negedge clk); check("irq_clr_t1", {31'd0, irq}, {31'd0, IRQ_ON});
        @(negedge clk); check("irq_clr_t2", {31'd0, irq}, 32'd0);
        irq_quiet = 1'b1;

        // reset while ch0 is stepping
        wcnt(0, 3, 0);
        ctrl(0, 32'h1, t);
        wait_cyc(t + 30);
        check("ch0_pre_rst", {31'd0, step_export[0]}, 32'd1);
        reset_dut();
        for (int ch = 0; ch < NCH; ch++)
            for (int rg = 0; rg < 4; rg++)
                rdl(ch, rg, $sformatf("post_rst_%0d_%0d", ch, rg), 32'd0);
        repeat (60) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
